// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing, test-pattern modes and the colour-bar palette.
package vga_pkg;

    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    typedef enum logic [1:0] {
        PAT_BARS    = 2'd0,
        PAT_CHECKER = 2'd1,
        PAT_GREY    = 2'd2,
        PAT_RED     = 2'd3
    } pattern_mode_e;

    // {r,g,b} on/off per bar, left to right
    localparam logic [2:0] BAR_RGB [8] = '{
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

endpackage

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: combinational test-pattern colour for one raster position.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_DISPLAY = VGA_H_DISPLAY,
    parameter int HW        = 10,
    parameter int VW        = 10,
    parameter int COLOR_W   = 8
) (
    input  logic               x5,
    input  logic [HW-1:0]      xs,
    input  logic [VW-1:0]      y,
    input  pattern_mode_e      mode,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b
);

    localparam logic [HW-1:0] BAR_W = HW'(H_DISPLAY / 8);

    logic [HW-1:0] bar;
    logic [2:0]    bar_rgb;
    logic          chk;

    always_comb begin
        bar     = xs / BAR_W;
        bar_rgb = (bar < HW'(8)) ? BAR_RGB[bar[2:0]] : 3'b000;
        chk     = ~(x5 ^ y[5]);
        r = (mode == PAT_BARS)    ? {COLOR_W{bar_rgb[2]}} :
            (mode == PAT_CHECKER) ? {COLOR_W{chk}} :
            (mode == PAT_GREY)    ? COLOR_W'(xs) : COLOR_W'(y);
        g = (mode == PAT_BARS)    ? {COLOR_W{bar_rgb[1]}} :
            (mode == PAT_CHECKER) ? {COLOR_W{chk}} :
            (mode == PAT_GREY)    ? COLOR_W'(xs) : '0;
        b = (mode == PAT_BARS)    ? {COLOR_W{bar_rgb[0]}} :
            (mode == PAT_CHECKER) ? {COLOR_W{chk}} :
            (mode == PAT_GREY)    ? COLOR_W'(xs) : '0;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing from a pixel clock-enable, with registered aligned outputs.
// Define VGA_PATTERN_SCROLL_EN to scroll the bars and grey ramp one pixel per frame.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_DISPLAY = VGA_H_DISPLAY,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_DISPLAY = VGA_V_DISPLAY,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CLK_DIV   = 2,
    parameter int COLOR_W   = 8,
    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK,
    localparam int HW       = $clog2(H_TOTAL),
    localparam int VW       = $clog2(V_TOTAL)
) (
    input  logic               clk_50MHz,
    input  logic               reset,
    input  logic [1:0]         mode,
    output logic               pixel_ce,
    output logic               hsync,
    output logic               vsync,
    output logic               video_active,
    output logic               frame_start,
    output logic [HW-1:0]      pixel_x,
    output logic [VW-1:0]      pixel_y,
    output logic [COLOR_W-1:0] pixel_r,
    output logic [COLOR_W-1:0] pixel_g,
    output logic [COLOR_W-1:0] pixel_b
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_DISPLAY);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_DISPLAY + H_FRONT);
    localparam logic [HW-1:0] HS_END   = HW'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_DISPLAY);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_DISPLAY + V_FRONT);
    localparam logic [VW-1:0] VS_END   = VW'(V_DISPLAY + V_FRONT + V_SYNC);

    if (H_DISPLAY % 8 != 0 || CLK_DIV < 1) begin : g_bad_params
        $error("vga_timing_gen: H_DISPLAY must be a multiple of 8 and CLK_DIV >= 1");
    end

    logic [DW-1:0]      div_q, div_d;
    logic [HW-1:0]      h_q, h_d, x_q, x_d, xs;
    logic [VW-1:0]      v_q, v_d, y_q, y_d;
    pattern_mode_e      mode_q, mode_d;
    logic               armed_q, armed_d;
    logic               hsync_q, hsync_d, vsync_q, vsync_d;
    logic               active_q, active_d, fs_q, fs_d;
    logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic [COLOR_W-1:0] pat_r, pat_g, pat_b;
    logic               h_last, frame_end, act_c;

    always_comb begin
        pixel_ce  = (div_q == DIV_LAST) && !reset;
        h_last    = h_q == H_LAST;
        frame_end = pixel_ce && h_last && v_q == V_LAST;
        div_d     = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        h_d       = !pixel_ce ? h_q : h_last ? '0 : h_q + 1'b1;
        v_d       = !(pixel_ce && h_last) ? v_q : (v_q == V_LAST) ? '0 : v_q + 1'b1;
        mode_d    = frame_end ? pattern_mode_e'(mode) : mode_q;
        armed_d   = armed_q || pixel_ce;
        act_c     = (h_q < H_ACT) && (v_q < V_ACT);
        x_d       = pixel_ce ? h_q : x_q;
        y_d       = pixel_ce ? v_q : y_q;
        hsync_d   = !pixel_ce ? hsync_q : (h_q >= HS_BEG && h_q < HS_END) ? HSYNC_POL : !HSYNC_POL;
        vsync_d   = !pixel_ce ? vsync_q : (v_q >= VS_BEG && v_q < VS_END) ? VSYNC_POL : !VSYNC_POL;
        active_d  = pixel_ce ? act_c : active_q;
        // (0,0) reached by wrapping marks a frame; the one loaded straight out of reset does not
        fs_d      = pixel_ce && armed_q && h_q == '0 && v_q == '0;
        r_d       = !pixel_ce ? r_q : act_c ? pat_r : '0;
        g_d       = !pixel_ce ? g_q : act_c ? pat_g : '0;
        b_d       = !pixel_ce ? b_q : act_c ? pat_b : '0;
    end

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            div_q    <= '0;
            h_q      <= '0;
            v_q      <= '0;
            mode_q   <= PAT_BARS;
            armed_q  <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            hsync_q  <= !HSYNC_POL;
            vsync_q  <= !VSYNC_POL;
            active_q <= 1'b0;
            fs_q     <= 1'b0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
        end else begin
            div_q    <= div_d;
            h_q      <= h_d;
            v_q      <= v_d;
            mode_q   <= mode_d;
            armed_q  <= armed_d;
            x_q      <= x_d;
            y_q      <= y_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            active_q <= active_d;
            fs_q     <= fs_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
        end
    end

`ifdef VGA_PATTERN_SCROLL_EN
    logic [HW-1:0] off_q, off_d;
    logic [HW:0]   xsum;

    always_comb begin
        off_d = !frame_end ? off_q : (off_q == H_ACT - 1'b1) ? '0 : off_q + 1'b1;
        xsum  = {1'b0, h_q} + {1'b0, off_q};
        xs    = (xsum >= {1'b0, H_ACT}) ? HW'(xsum - {1'b0, H_ACT}) : xsum[HW-1:0];
    end

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            off_q <= '0;
        end else begin
            off_q <= off_d;
        end
    end
`else
    assign xs = h_q;
`endif

    vga_pattern_gen #(
        .H_DISPLAY (H_DISPLAY),
        .HW        (HW),
        .VW        (VW),
        .COLOR_W   (COLOR_W)
    ) u_pattern (
        .x5   (h_q[5]),
        .xs   (xs),
        .y    (v_q),
        .mode (mode_q),
        .r    (pat_r),
        .g    (pat_g),
        .b    (pat_b)
    );

    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign video_active = active_q;
    assign frame_start  = fs_q;
    assign pixel_x      = x_q;
    assign pixel_y      = y_q;
    assign pixel_r      = r_q;
    assign pixel_g      = g_q;
    assign pixel_b      = b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on a small 80x40 raster (CLK_DIV=2) plus a
// full-width 640-pixel line with HSYNC_POL=1, CLK_DIV=1.
module tb_vga_timing_gen;

`ifdef VGA_PATTERN_SCROLL_EN
    localparam bit SCROLL = 1'b1;
`else
    localparam bit SCROLL = 1'b0;
`endif
    localparam int FRAME_PIX = 100 * 48;

    typedef struct {
        int          f, x, y;
        bit          hs, vs, act, fs;
        logic [23:0] rgb;
        logic [1:0]  m;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mode = 2'd0;
    logic [1:0] mode_b = 2'd0;
    logic       pce, hs, vs, act, fs;
    logic [6:0] px;
    logic [5:0] py;
    logic [7:0] pr, pg, pb;
    logic       pce_b, hs_b, vs_b, act_b, fs_b;
    logic [9:0] px_b, py_b;
    logic [7:0] pr_b, pg_b, pb_b;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   rel_b = 1'b0;
    int   mon_clk = 0;
    int   fs_wide = 0;
    bit   fs_prev = 1'b0;
    int   fs_at[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_DISPLAY(80), .H_FRONT(4), .H_SYNC(8), .H_BACK(8),
        .V_DISPLAY(40), .V_FRONT(2), .V_SYNC(2), .V_BACK(4)
    ) dut (
        .clk_50MHz(clk), .reset(reset), .mode(mode), .pixel_ce(pce),
        .hsync(hs), .vsync(vs), .video_active(act), .frame_start(fs),
        .pixel_x(px), .pixel_y(py), .pixel_r(pr), .pixel_g(pg), .pixel_b(pb)
    );

    vga_timing_gen #(
        .HSYNC_POL(1'b1), .CLK_DIV(1)
    ) dut_b (
        .clk_50MHz(clk), .reset(reset), .mode(mode_b), .pixel_ce(pce_b),
        .hsync(hs_b), .vsync(vs_b), .video_active(act_b), .frame_start(fs_b),
        .pixel_x(px_b), .pixel_y(py_b), .pixel_r(pr_b), .pixel_g(pg_b), .pixel_b(pb_b)
    );

    task automatic chk(input string name, input int act_v, input int exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // with CLK_DIV=2 the edge numbered 2p+2 after release loads pixel p
    task automatic run_to(input int p);
        while (cyc < 2 * p + 2) step();
    endtask

    function automatic int pix(input int f, input int x, input int y);
        return f * FRAME_PIX + y * 100 + x;
    endfunction

    function automatic vec_t mk(input int f, input int x, input int y, input bit h, input bit v,
                                input bit a, input bit s, input logic [23:0] c, input logic [1:0] m);
        vec_t t;
        t.f = f; t.x = x; t.y = y; t.hs = h; t.vs = v; t.act = a; t.fs = s; t.rgb = c; t.m = m;
        return t;
    endfunction

    initial forever begin
        @(negedge clk);
        mon_clk++;
        if (fs) fs_at.push_back(mon_clk);
        if (fs && fs_prev) fs_wide++;
        fs_prev = fs;
    end

    initial begin
        wait (rel_b);
        #1;
        chk("B ce on release", int'(pce_b), 1);
        for (int e = 1; e <= 800; e++) begin
            @(posedge clk);
            #1;
            chk("B pixel_ce", int'(pce_b), 1);
            chk("B pixel_x", int'(px_b), e - 1);
            chk($sformatf("B hsync x=%0d", e - 1), int'(hs_b), (e - 1 >= 656 && e - 1 < 752) ? 1 : 0);
        end
    end

    initial begin
        vec_t  t;
        string n;
        vecs.push_back(mk(0,  0,  0, 1, 1, 1, 0, 24'hFFFFFF, 2'd0));
        vecs.push_back(mk(0,  9, 10, 1, 1, 1, 0, 24'hFFFFFF, 2'd0));
        vecs.push_back(mk(0, 10, 10, 1, 1, 1, 0, 24'hFFFF00, 2'd0));
        vecs.push_back(mk(0, 20, 10, 1, 1, 1, 0, 24'h00FFFF, 2'd0));
        vecs.push_back(mk(0, 35, 10, 1, 1, 1, 0, 24'h00FF00, 2'd0));
        vecs.push_back(mk(0, 45, 10, 1, 1, 1, 0, 24'hFF00FF, 2'd0));
        vecs.push_back(mk(0, 55, 10, 1, 1, 1, 0, 24'hFF0000, 2'd0));
        vecs.push_back(mk(0, 65, 10, 1, 1, 1, 0, 24'h0000FF, 2'd0));
        vecs.push_back(mk(0, 70, 10, 1, 1, 1, 0, 24'h000000, 2'd0));
        vecs.push_back(mk(0, 79, 10, 1, 1, 1, 0, 24'h000000, 2'd0));
        vecs.push_back(mk(0, 80, 10, 1, 1, 0, 0, 24'h000000, 2'd0));
        vecs.push_back(mk(0, 84, 10, 0, 1, 0, 0, 24'h000000, 2'd0));
        vecs.push_back(mk(0, 91, 10, 0, 1, 0, 0, 24'h000000, 2'd0));
        vecs.push_back(mk(0, 92, 10, 1, 1, 0, 0, 24'h000000, 2'd0));
        vecs.push_back(mk(0, 50, 20, 1, 1, 1, 0, 24'hFF0000, 2'd1));
        vecs.push_back(mk(0, 10, 30, 1, 1, 1, 0, 24'hFFFF00, 2'd1));
        vecs.push_back(mk(0,  0, 41, 1, 1, 0, 0, 24'h000000, 2'd1));
        vecs.push_back(mk(0,  0, 42, 1, 0, 0, 0, 24'h000000, 2'd1));
        vecs.push_back(mk(0, 99, 43, 1, 0, 0, 0, 24'h000000, 2'd1));
        vecs.push_back(mk(0,  0, 44, 1, 1, 0, 0, 24'h000000, 2'd1));
        vecs.push_back(mk(1,  0,  0, 1, 1, 1, 1, 24'hFFFFFF, 2'd1));
        vecs.push_back(mk(1, 31,  0, 1, 1, 1, 0, 24'hFFFFFF, 2'd1));
        vecs.push_back(mk(1, 32,  0, 1, 1, 1, 0, 24'h000000, 2'd1));
        vecs.push_back(mk(1,  0, 32, 1, 1, 1, 0, 24'h000000, 2'd1));
        vecs.push_back(mk(1, 32, 32, 1, 1, 1, 0, 24'hFFFFFF, 2'd2));
        vecs.push_back(mk(2,  5,  3, 1, 1, 1, 0, SCROLL ? 24'h070707 : 24'h050505, 2'd2));
        vecs.push_back(mk(2, 79,  3, 1, 1, 1, 0, SCROLL ? 24'h010101 : 24'h4F4F4F, 2'd3));
        vecs.push_back(mk(3,  7, 37, 1, 1, 1, 0, 24'h250000, 2'd3));
        vecs.push_back(mk(3, 79, 39, 1, 1, 1, 0, 24'h270000, 2'd3));
        vecs.push_back(mk(3, 80, 39, 1, 1, 0, 0, 24'h000000, 2'd0));
        vecs.push_back(mk(4,  6,  5, 1, 1, 1, 0, SCROLL ? 24'hFFFF00 : 24'hFFFFFF, 2'd0));
        vecs.push_back(mk(4, 79,  5, 1, 1, 1, 0, SCROLL ? 24'hFFFFFF : 24'h000000, 2'd0));

        repeat (2) @(posedge clk);
        #1;
        chk("rst pixel_ce", int'(pce), 0);
        chk("rst hsync", int'(hs), 1);
        chk("rst vsync", int'(vs), 1);
        chk("rst active", int'(act), 0);
        chk("rst frame_start", int'(fs), 0);
        chk("rst pixel_x", int'(px), 0);
        chk("rst pixel_y", int'(py), 0);
        chk("rst rgb", int'({pr, pg, pb}), 0);
        chk("B rst hsync", int'(hs_b), 0);
        chk("B rst pixel_ce", int'(pce_b), 0);
        reset = 1'b0;
        rel_b = 1'b1;
        cyc = 0;
        chk("ce after release", int'(pce), 0);
        step();
        chk("first ce", int'(pce), 1);

        foreach (vecs[i]) begin
            t = vecs[i];
            run_to(pix(t.f, t.x, t.y));
            n = $sformatf("f%0d(%0d,%0d)", t.f, t.x, t.y);
            chk({n, " pixel_x"}, int'(px), t.x);
            chk({n, " pixel_y"}, int'(py), t.y);
            chk({n, " hsync"}, int'(hs), int'(t.hs));
            chk({n, " vsync"}, int'(vs), int'(t.vs));
            chk({n, " active"}, int'(act), int'(t.act));
            chk({n, " frame_start"}, int'(fs), int'(t.fs));
            chk({n, " rgb"}, int'({pr, pg, pb}), int'(t.rgb));
            mode = t.m;
        end

        for (int x = 0; x < 100; x++) begin
            run_to(pix(4, x, 6));
            chk($sformatf("line hsync x=%0d", x), int'(hs), (x >= 84 && x < 92) ? 0 : 1);
            chk($sformatf("line active x=%0d", x), int'(act), (x < 80) ? 1 : 0);
        end

        run_to(pix(4, 30, 20));
        chk("ce low after strobe", int'(pce), 0);
        step();
        chk("ce high mid pixel", int'(pce), 1);
        chk("x stable between strobes", int'(px), 30);
        mode = 2'd1;
        reset = 1'b1;
        step();
        chk("mid rst pixel_ce", int'(pce), 0);
        chk("mid rst hsync", int'(hs), 1);
        chk("mid rst vsync", int'(vs), 1);
        chk("mid rst active", int'(act), 0);
        chk("mid rst frame_start", int'(fs), 0);
        chk("mid rst pixel_x", int'(px), 0);
        chk("mid rst pixel_y", int'(py), 0);
        chk("mid rst rgb", int'({pr, pg, pb}), 0);
        reset = 1'b0;
        cyc = 0;
        step();
        chk("post rst first ce", int'(pce), 1);
        step();
        chk("post rst pixel_x", int'(px), 0);
        chk("post rst pixel_y", int'(py), 0);
        chk("post rst active", int'(act), 1);
        run_to(10);
        chk("post rst mode_q cleared rgb", int'({pr, pg, pb}), 32'hFFFF00);

        chk("frame_start count", fs_at.size(), 4);
        for (int i = 1; i < fs_at.size(); i++)
            chk($sformatf("frame_start spacing %0d", i), fs_at[i] - fs_at[i-1], 2 * FRAME_PIX);
        chk("frame_start width", fs_wide, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
